// File: rtl/vga_pkg.sv
// Shared types and constants for the game scene controller.
// Holds the scene encoding, the move directions and the default start coordinates.
package vga_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } scene_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // p2 starts START_MARGIN pixels left of the right-most legal x
  localparam int P1_START_X   = 64;
  localparam int START_MARGIN = 64;
  localparam int START_Y      = 300;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; on a tie the requester not granted last wins.
// The last-grant pointer resets so that p1 (req[0]) is favoured first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_p2;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_p2)) gnt = 2'b01;
    else if (req[1])                    gnt = 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_p2 <= 1'b1;
    else if (gnt[0]) last_p2 <= 1'b0;
    else if (gnt[1]) last_p2 <= 1'b1;
  end

endmodule

// File: rtl/gra_scene_ctrl.sv
// Frame-synchronous scene controller: scene FSM, shared move datapath, frame-stable outputs.
// Optional PAUSE scene is compiled only when GRA_SCENE_PAUSE_EN is defined.
import vga_pkg::*;

module gra_scene_ctrl #(
  parameter int X_W          = 11,
  parameter int Y_W          = 11,
  parameter int STEP         = 4,
  parameter int X_MAX        = 767,
  parameter int Y_MAX        = 567,
  parameter int ANIM_DIV     = 8,
  parameter int ROUND_FRAMES = 1800
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vblnk,
  input  logic           start,
  input  logic           pause,
  input  logic           p1_req,
  input  logic [1:0]     p1_dir,
  input  logic           p2_req,
  input  logic [1:0]     p2_dir,
  output logic           p1_ack,
  output logic           p2_ack,
  output logic [X_W-1:0] p1_xpos,
  output logic [Y_W-1:0] p1_ypos,
  output logic [X_W-1:0] p2_xpos,
  output logic [Y_W-1:0] p2_ypos,
  output logic [1:0]     anim_frame,
  output scene_t         scene,
  output logic           char_en,
  output logic [10:0]    frames_left
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [X_W:0]   STEP_X  = (X_W+1)'(STEP);
  localparam logic [Y_W:0]   STEP_Y  = (Y_W+1)'(STEP);
  localparam logic [X_W:0]   LIMIT_X = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   LIMIT_Y = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0] P1_X0   = X_W'(P1_START_X);
  localparam logic [X_W-1:0] P2_X0   = X_W'(X_MAX - START_MARGIN);
  localparam logic [Y_W-1:0] Y0      = Y_W'(START_Y);

  // Moves are computed one bit wider: the carry/borrow bit drives the clamp
  function automatic logic [X_W-1:0] move_x(input logic [X_W-1:0] cur, input logic inc);
    logic [X_W:0] w;
    if (inc) begin
      w = {1'b0, cur} + STEP_X;
      if (w > LIMIT_X) w = LIMIT_X;
    end else begin
      w = {1'b0, cur} - STEP_X;
      if (w[X_W]) w = '0;
    end
    return w[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] move_y(input logic [Y_W-1:0] cur, input logic inc);
    logic [Y_W:0] w;
    if (inc) begin
      w = {1'b0, cur} + STEP_Y;
      if (w > LIMIT_Y) w = LIMIT_Y;
    end else begin
      w = {1'b0, cur} - STEP_Y;
      if (w[Y_W]) w = '0;
    end
    return w[Y_W-1:0];
  endfunction

  logic [1:0]       gnt;
  logic             vblnk_q, frame_ev;
  logic [DIV_W-1:0] anim_div;
  logic [X_W-1:0]   p1_sx, p2_sx, p1_sx_n, p2_sx_n;
  logic [Y_W-1:0]   p1_sy, p2_sy, p1_sy_n, p2_sy_n;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({p2_req, p1_req} & {2{scene == PLAY}}),
    .gnt (gnt)
  );

  assign p1_ack   = gnt[0];
  assign p2_ack   = gnt[1];
  assign char_en  = (scene != MENU);
  assign frame_ev = vblnk & ~vblnk_q;

`ifndef GRA_SCENE_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_comb begin
    p1_sx_n = p1_sx;
    p1_sy_n = p1_sy;
    p2_sx_n = p2_sx;
    p2_sy_n = p2_sy;
    if (gnt[0]) begin
      case (p1_dir)
        DIR_UP:    p1_sy_n = move_y(p1_sy, 1'b0);
        DIR_DOWN:  p1_sy_n = move_y(p1_sy, 1'b1);
        DIR_LEFT:  p1_sx_n = move_x(p1_sx, 1'b0);
        DIR_RIGHT: p1_sx_n = move_x(p1_sx, 1'b1);
      endcase
    end
    if (gnt[1]) begin
      case (p2_dir)
        DIR_UP:    p2_sy_n = move_y(p2_sy, 1'b0);
        DIR_DOWN:  p2_sy_n = move_y(p2_sy, 1'b1);
        DIR_LEFT:  p2_sx_n = move_x(p2_sx, 1'b0);
        DIR_RIGHT: p2_sx_n = move_x(p2_sx, 1'b1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vblnk_q <= 1'b0;
    else      vblnk_q <= vblnk;
  end

  // Outputs copy the pre-update shadow, so a same-cycle move waits a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scene       <= MENU;
      frames_left <= '0;
      anim_div    <= '0;
      anim_frame  <= '0;
      p1_sx <= P1_X0;  p1_sy <= Y0;  p2_sx <= P2_X0;  p2_sy <= Y0;
      p1_xpos <= P1_X0;  p1_ypos <= Y0;  p2_xpos <= P2_X0;  p2_ypos <= Y0;
    end else begin
      p1_sx <= p1_sx_n;  p1_sy <= p1_sy_n;  p2_sx <= p2_sx_n;  p2_sy <= p2_sy_n;
      if (frame_ev) begin
        p1_xpos <= p1_sx;  p1_ypos <= p1_sy;  p2_xpos <= p2_sx;  p2_ypos <= p2_sy;
      end
      if (frame_ev && scene == PLAY) begin
        if (frames_left != '0) frames_left <= frames_left - 11'd1;
        if (anim_div == DIV_W'(ANIM_DIV - 1)) begin
          anim_div   <= '0;
          anim_frame <= anim_frame + 2'd1;
        end else begin
          anim_div <= anim_div + DIV_W'(1);
        end
      end
      case (scene)
        MENU: if (start) begin
          scene       <= PLAY;
          frames_left <= 11'(ROUND_FRAMES);
          p1_sx <= P1_X0;  p1_sy <= Y0;  p2_sx <= P2_X0;  p2_sy <= Y0;
          p1_xpos <= P1_X0;  p1_ypos <= Y0;  p2_xpos <= P2_X0;  p2_ypos <= Y0;
        end
        PLAY: begin
          if (frame_ev && frames_left <= 11'd1) scene <= OVER;
`ifdef GRA_SCENE_PAUSE_EN
          else if (pause)                       scene <= PAUSE;
`endif
        end
`ifdef GRA_SCENE_PAUSE_EN
        PAUSE: if (pause) scene <= PLAY;
`endif
        OVER: if (start) scene <= MENU;
        default: scene <= MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_gra_scene_ctrl.sv
// Scoreboard bench for gra_scene_ctrl: expected acks are queued by stimulus and popped by a monitor.
// Directed vectors cover reset, moves, arbitration, saturation, frame timing and round end.
module tb_gra_scene_ctrl;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst, vblnk, start, pause;
  logic        p1_req, p2_req;
  logic [1:0]  p1_dir, p2_dir;
  logic        p1_ack, p2_ack;
  logic [10:0] p1_xpos, p1_ypos, p2_xpos, p2_ypos;
  logic [1:0]  anim_frame;
  scene_t      scene;
  logic        char_en;
  logic [10:0] frames_left;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  gra_scene_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .start       (start),
    .pause       (pause),
    .p1_req      (p1_req),
    .p1_dir      (p1_dir),
    .p2_req      (p2_req),
    .p2_dir      (p2_dir),
    .p1_ack      (p1_ack),
    .p2_ack      (p2_ack),
    .p1_xpos     (p1_xpos),
    .p1_ypos     (p1_ypos),
    .p2_xpos     (p2_xpos),
    .p2_ypos     (p2_ypos),
    .anim_frame  (anim_frame),
    .scene       (scene),
    .char_en     (char_en),
    .frames_left (frames_left)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request pattern for 'cycles' cycles, queueing one expected ack per cycle
  task automatic applyStimulus(input logic r1, input logic [1:0] d1, input logic r2,
                               input logic [1:0] d2, input logic [1:0] exp_ack, input int cycles);
    p1_req = r1;  p1_dir = d1;  p2_req = r2;  p2_dir = d2;
    repeat (cycles) begin
      if (exp_ack != 2'b00) exp_q.push_back(exp_ack);
      step();
    end
    p1_req = 1'b0;
    p2_req = 1'b0;
  endtask

  task automatic frame();
    vblnk = 1'b1;
    step();
    vblnk = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (p1_ack === 1'b1 || p2_ack === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_ack: got %b, expected none", {p2_ack, p1_ack});
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("ack", {30'd0, p2_ack, p1_ack}, {30'd0, mon_exp});
      end
    end
  end

  initial begin
    rst = 1'b0;  vblnk = 1'b0;  start = 1'b0;  pause = 1'b0;
    p1_req = 1'b0;  p2_req = 1'b0;  p1_dir = 2'd0;  p2_dir = 2'd0;
    repeat (3) step();
    checkOutput("rst_scene", scene, MENU);
    checkOutput("rst_frames_left", frames_left, 0);
    checkOutput("rst_char_en", char_en, 0);
    checkOutput("rst_anim", anim_frame, 0);
    checkOutput("rst_p1x", p1_xpos, 64);
    checkOutput("rst_p1y", p1_ypos, 300);
    checkOutput("rst_p2x", p2_xpos, 703);
    checkOutput("rst_p2y", p2_ypos, 300);
    rst = 1'b1;
    step();

    // Requests in MENU must be dropped, even across a frame copy
    applyStimulus(1'b1, DIR_RIGHT, 1'b1, DIR_RIGHT, 2'b00, 3);
    frame();
    checkOutput("menu_p1x", p1_xpos, 64);
    checkOutput("menu_p2x", p2_xpos, 703);
    checkOutput("menu_frames_left", frames_left, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("play_scene", scene, PLAY);
    checkOutput("play_frames_left", frames_left, 1800);
    checkOutput("play_char_en", char_en, 1);

    applyStimulus(1'b1, DIR_RIGHT, 1'b0, DIR_UP, 2'b01, 3);
    step();
    checkOutput("p1x_mid_frame", p1_xpos, 64);
    vblnk = 1'b1;
    @(negedge clk);
    checkOutput("p1x_pre_edge", p1_xpos, 64);
    @(posedge clk);
    #1;
    checkOutput("p1x_post_edge", p1_xpos, 76);
    step();
    checkOutput("p1x_vblnk_held", p1_xpos, 76);
    vblnk = 1'b0;
    step();
    checkOutput("frames_left_1", frames_left, 1799);

    // Pointer last served p1, so the tie goes p2 first
    applyStimulus(1'b1, DIR_DOWN, 1'b1, DIR_LEFT, 2'b10, 1);
    applyStimulus(1'b1, DIR_DOWN, 1'b1, DIR_LEFT, 2'b01, 1);
    applyStimulus(1'b1, DIR_DOWN, 1'b1, DIR_LEFT, 2'b10, 1);
    applyStimulus(1'b1, DIR_DOWN, 1'b1, DIR_LEFT, 2'b01, 1);

    applyStimulus(1'b0, DIR_UP, 1'b1, DIR_UP, 2'b10, 80);
    applyStimulus(1'b1, DIR_RIGHT, 1'b0, DIR_UP, 2'b01, 175);
    frame();
    checkOutput("p1x_sat_max", p1_xpos, 767);
    checkOutput("p1y_after_tie", p1_ypos, 308);
    checkOutput("p2x_after_tie", p2_xpos, 695);
    checkOutput("p2y_sat_zero", p2_ypos, 0);
    checkOutput("frames_left_2", frames_left, 1798);

    applyStimulus(1'b0, DIR_UP, 1'b1, DIR_DOWN, 2'b10, 150);
    applyStimulus(1'b0, DIR_UP, 1'b1, DIR_UP, 2'b10, 141);
    frame();
    checkOutput("p2y_near_zero", p2_ypos, 3);
    applyStimulus(1'b0, DIR_UP, 1'b1, DIR_UP, 2'b10, 1);

    // Move accepted on the frame-event cycle is held back one frame
    p1_req = 1'b1;
    p1_dir = DIR_LEFT;
    exp_q.push_back(2'b01);
    vblnk = 1'b1;
    step();
    p1_req = 1'b0;
    vblnk = 1'b0;
    checkOutput("p1x_same_cycle", p1_xpos, 767);
    checkOutput("p2y_clamp_from_3", p2_ypos, 0);
    step();
    frame();
    checkOutput("p1x_next_frame", p1_xpos, 763);
    checkOutput("frames_left_5", frames_left, 1795);
    checkOutput("anim_after_5", anim_frame, 0);

`ifdef GRA_SCENE_PAUSE_EN
    pause = 1'b1;
    step();
    pause = 1'b0;
    checkOutput("pause_scene", scene, PAUSE);
    applyStimulus(1'b1, DIR_UP, 1'b1, DIR_UP, 2'b00, 2);
    repeat (10) frame();
    checkOutput("pause_frames_frozen", frames_left, 1795);
    checkOutput("pause_p1y", p1_ypos, 308);
    pause = 1'b1;
    step();
    pause = 1'b0;
    checkOutput("resume_scene", scene, PLAY);
`else
    pause = 1'b1;
    step();
    pause = 1'b0;
    checkOutput("pause_ignored_scene", scene, PLAY);
    checkOutput("pause_ignored_frames", frames_left, 1795);
`endif

    repeat (11) frame();
    checkOutput("frames_left_16", frames_left, 1784);
    checkOutput("anim_after_16", anim_frame, 2);
    repeat (1783) frame();
    checkOutput("last_frame_scene", scene, PLAY);
    checkOutput("last_frame_left", frames_left, 1);
    frame();
    checkOutput("over_scene", scene, OVER);
    checkOutput("over_frames_left", frames_left, 0);
    checkOutput("over_anim", anim_frame, 1);
    checkOutput("over_char_en", char_en, 1);
    applyStimulus(1'b1, DIR_LEFT, 1'b1, DIR_LEFT, 2'b00, 3);

    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("menu_again_scene", scene, MENU);
    checkOutput("menu_again_char_en", char_en, 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("replay_scene", scene, PLAY);
    checkOutput("replay_frames_left", frames_left, 1800);
    checkOutput("replay_p1x", p1_xpos, 64);
    checkOutput("replay_p1y", p1_ypos, 300);
    checkOutput("replay_p2x", p2_xpos, 703);
    checkOutput("replay_p2y", p2_ypos, 300);

    step();
    checkOutput("ack_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
